// File: rtl/uart_frame_tx_if.sv
// Frame-offer handshake between a byte source and uart_frame_tx.
// The source drives payload plus per-frame format; the transmitter answers with ready.
interface uart_frame_tx_if #(
    parameter int unsigned DATA_WIDTH = 8
) ();
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_ready;
    logic [1:0]            parity_type;
    logic                  stop_bits;

    modport master (
        output tx_data,
        output tx_valid,
        output parity_type,
        output stop_bits,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        input  parity_type,
        input  stop_bits,
        output tx_ready
    );
endinterface

// File: rtl/uart_frame_tx.sv
// UART frame transmitter: start bit, LSB-first payload, optional parity, one or two stop bits,
// with every line transition aligned to baud_tick.
module uart_frame_tx #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             baud_tick,
    uart_frame_tx_if.slave   tx_if,
    output logic             tx_out,
    output logic             tx_busy,
    output logic             tx_done
);
    localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARM    = 3'd1,
        S_START  = 3'd2,
        S_DATA   = 3'd3,
        S_PARITY = 3'd4,
        S_STOP   = 3'd5
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [DATA_WIDTH-1:0] r_shift;
    logic [1:0]            r_parity_type;
    logic                  r_stop_bits;
    logic                  r_par_bit;
    logic [CNT_W-1:0]      r_bit_cnt;
    logic                  r_stop_cnt;
    logic                  r_tx_out;
    logic                  r_tx_busy;
    logic                  r_tx_ready;
    logic                  r_tx_done;

    logic                  w_load;
    logic                  w_shift_en;
    logic                  w_par_en;
    logic [CNT_W-1:0]      w_bit_cnt_nxt;
    logic                  w_stop_cnt_nxt;
    logic                  w_tx_out_nxt;
    logic                  w_tx_done_nxt;
    logic                  w_par_bit_cap;

    assign w_par_en      = (r_parity_type == 2'b01) || (r_parity_type == 2'b10);
    // Odd parity inverts the reduction so data plus parity carries an odd count of ones.
    assign w_par_bit_cap = (tx_if.parity_type == 2'b01) ? ~^tx_if.tx_data : ^tx_if.tx_data;

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (tx_if.tx_valid) begin
                    w_state_nxt = S_ARM;
                end
            end
            S_ARM: begin
                if (baud_tick) begin
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (baud_tick) begin
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (baud_tick && (r_bit_cnt == LAST_BIT)) begin
                    w_state_nxt = w_par_en ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (baud_tick) begin
                    w_state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                if (baud_tick && (r_stop_cnt == r_stop_bits)) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Output and datapath next values; the line only moves on a baud_tick.
    always_comb begin
        w_load         = 1'b0;
        w_shift_en     = 1'b0;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_stop_cnt_nxt = r_stop_cnt;
        w_tx_out_nxt   = r_tx_out;
        w_tx_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_load         = tx_if.tx_valid;
                w_bit_cnt_nxt  = '0;
                w_stop_cnt_nxt = 1'b0;
                w_tx_out_nxt   = 1'b1;
            end
            S_ARM: begin
                if (baud_tick) begin
                    w_tx_out_nxt = 1'b0;
                end
            end
            S_START: begin
                if (baud_tick) begin
                    w_tx_out_nxt  = r_shift[0];
                    w_shift_en    = 1'b1;
                    w_bit_cnt_nxt = '0;
                end
            end
            S_DATA: begin
                if (baud_tick) begin
                    if (r_bit_cnt == LAST_BIT) begin
                        w_tx_out_nxt   = w_par_en ? r_par_bit : 1'b1;
                        w_stop_cnt_nxt = 1'b0;
                    end else begin
                        w_tx_out_nxt  = r_shift[0];
                        w_shift_en    = 1'b1;
                        w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
                    end
                end
            end
            S_PARITY: begin
                if (baud_tick) begin
                    w_tx_out_nxt   = 1'b1;
                    w_stop_cnt_nxt = 1'b0;
                end
            end
            S_STOP: begin
                if (baud_tick) begin
                    w_tx_out_nxt = 1'b1;
                    if (r_stop_cnt == r_stop_bits) begin
                        w_tx_done_nxt = 1'b1;
                    end else begin
                        w_stop_cnt_nxt = 1'b1;
                    end
                end
            end
            default: begin
                w_tx_out_nxt = 1'b1;
            end
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_shift       <= '0;
            r_parity_type <= 2'b00;
            r_stop_bits   <= 1'b0;
            r_par_bit     <= 1'b0;
            r_bit_cnt     <= '0;
            r_stop_cnt    <= 1'b0;
            r_tx_out      <= 1'b1;
            r_tx_done     <= 1'b0;
            r_tx_busy     <= 1'b0;
            r_tx_ready    <= 1'b1;
        end else begin
            if (w_load) begin
                r_shift       <= tx_if.tx_data;
                r_parity_type <= tx_if.parity_type;
                r_stop_bits   <= tx_if.stop_bits;
                r_par_bit     <= w_par_bit_cap;
            end else if (w_shift_en) begin
                r_shift <= r_shift >> 1;
            end
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_stop_cnt <= w_stop_cnt_nxt;
            r_tx_out   <= w_tx_out_nxt;
            r_tx_done  <= w_tx_done_nxt;
            r_tx_busy  <= (w_state_nxt != S_IDLE);
            r_tx_ready <= (w_state_nxt == S_IDLE);
        end
    end

    assign tx_if.tx_ready = r_tx_ready;
    assign tx_out         = r_tx_out;
    assign tx_busy        = r_tx_busy;
    assign tx_done        = r_tx_done;
endmodule

// File: tb/tb_uart_frame_tx.sv
// Bench for uart_frame_tx: a frame-level reference model (a queue of line bits per accepted frame)
// is compared against the DUT every cycle, plus literal line sequences for known frames.
module tb_uart_frame_tx;
    localparam int unsigned DW = 8;

    logic clk = 1'b0;
    logic reset_n;
    logic baud_tick;
    logic tx_out;
    logic tx_busy;
    logic tx_done;

    uart_frame_tx_if #(.DATA_WIDTH(DW)) u_if ();

    uart_frame_tx #(.DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .baud_tick (baud_tick),
        .tx_if     (u_if.slave),
        .tx_out    (tx_out),
        .tx_busy   (tx_busy),
        .tx_done   (tx_done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %b want %b", name, $time, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d want %0d", name, $time, act, exp);
        end
    endtask

    // Line bits of one frame, in transmit order, from the frame format rules.
    function automatic void build_frame(input logic [7:0] d, input logic [1:0] p, input logic s,
                                        output bit q[$]);
        int ones;
        q.delete();
        q.push_back(1'b0);
        for (int i = 0; i < 8; i++) q.push_back(d[i]);
        if (p == 2'b01 || p == 2'b10) begin
            ones = $countones(d);
            q.push_back((p == 2'b10) ? bit'(ones % 2) : bit'(1 - ones % 2));
        end
        q.push_back(1'b1);
        if (s) q.push_back(1'b1);
    endfunction

    // Reference model: idle flag, current line level, and the bits still to send.
    bit m_en   = 1'b0;
    bit m_idle = 1'b1;
    bit m_line = 1'b1;
    bit m_done = 1'b0;
    bit m_q[$];

    always @(posedge clk) begin
        if (!reset_n) begin
            m_en   = 1'b1;
            m_idle = 1'b1;
            m_line = 1'b1;
            m_done = 1'b0;
            m_q.delete();
        end else begin
            m_done = 1'b0;
            if (m_idle) begin
                if (u_if.tx_valid) begin
                    build_frame(u_if.tx_data, u_if.parity_type, u_if.stop_bits, m_q);
                    m_idle = 1'b0;
                end
            end else if (baud_tick) begin
                if (m_q.size() == 0) begin
                    m_idle = 1'b1;
                    m_done = 1'b1;
                end else begin
                    m_line = m_q.pop_front();
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_en) begin
            check_bit("tx_out",   tx_out,        m_line);
            check_bit("tx_ready", u_if.tx_ready, m_idle);
            check_bit("tx_busy",  tx_busy,       !m_idle);
            check_bit("tx_done",  tx_done,       m_done);
        end
    end

    task automatic scramble_fields();
        u_if.tx_data     = 8'($urandom);
        u_if.parity_type = 2'($urandom);
        u_if.stop_bits   = 1'($urandom);
    endtask

    // Offer one frame (with a tick in the accept cycle), tick it out while scrambling the
    // inputs, and compare the collected line bits to a literal sequence.
    task automatic send_frame(input string name, input logic [7:0] d, input logic [1:0] p,
                              input logic s, input logic [15:0] exp, input int exp_len);
        logic [15:0] log;
        int          n;
        bit          done_seen;
        @(negedge clk);
        u_if.tx_valid    = 1'b1;
        u_if.tx_data     = d;
        u_if.parity_type = p;
        u_if.stop_bits   = s;
        baud_tick        = 1'b1;
        @(negedge clk);
        u_if.tx_valid = 1'b0;
        baud_tick     = 1'b0;
        log       = '0;
        n         = 0;
        done_seen = 1'b0;
        for (int k = 0; k < 20 && tx_busy; k++) begin
            repeat (2) begin
                @(negedge clk);
                scramble_fields();
                u_if.tx_valid = 1'($urandom);
            end
            baud_tick = 1'b1;
            @(negedge clk);
            baud_tick     = 1'b0;
            u_if.tx_valid = 1'b0;
            if (tx_busy) begin
                log = {log[14:0], tx_out};
                n++;
            end else begin
                done_seen = (tx_done === 1'b1);
            end
        end
        check_int({name, "_len"}, n, exp_len);
        check_int({name, "_bits"}, int'(log), int'(exp));
        check_bit({name, "_done"}, done_seen, 1'b1);
        @(negedge clk);
    endtask

    initial begin
        bit q[$];
        logic [15:0] packed_q;
        int dones;
        int cyc;
        bit switched;

        reset_n          = 1'b0;
        baud_tick        = 1'b0;
        u_if.tx_valid    = 1'b0;
        u_if.tx_data     = '0;
        u_if.parity_type = 2'b00;
        u_if.stop_bits   = 1'b0;

        // Pin the model itself with hand-derived frames.
        build_frame(8'hA5, 2'b10, 1'b0, q);
        packed_q = '0;
        foreach (q[i]) packed_q = {packed_q[14:0], 1'(q[i])};
        check_int("model_a5_even", int'(packed_q), 16'b01010010101);
        build_frame(8'h07, 2'b01, 1'b1, q);
        packed_q = '0;
        foreach (q[i]) packed_q = {packed_q[14:0], 1'(q[i])};
        check_int("model_07_odd_2stop", int'(packed_q), 16'b011100000011);

        repeat (3) @(negedge clk);
        check_bit("rst_tx_out", tx_out, 1'b1);
        check_bit("rst_busy", tx_busy, 1'b0);
        check_bit("rst_ready", u_if.tx_ready, 1'b1);
        reset_n = 1'b1;
        @(negedge clk);

        send_frame("a5_even", 8'hA5, 2'b10, 1'b0, 16'b01010010101, 11);
        send_frame("07_odd",  8'h07, 2'b01, 1'b0, 16'b01110000001, 11);
        send_frame("07_even", 8'h07, 2'b10, 1'b0, 16'b01110000011, 11);
        send_frame("a5_odd",  8'hA5, 2'b01, 1'b0, 16'b01010010111, 11);
        send_frame("00_2stop", 8'h00, 2'b11, 1'b1, 16'b00000000011, 11);

        // Back-to-back with tx_valid held high: 0x55 then 0x3C.
        @(negedge clk);
        u_if.tx_valid    = 1'b1;
        u_if.tx_data     = 8'h55;
        u_if.parity_type = 2'b00;
        u_if.stop_bits   = 1'b0;
        dones    = 0;
        switched = 1'b0;
        for (cyc = 0; cyc < 300 && !(dones == 2 && !tx_busy); cyc++) begin
            baud_tick = (cyc % 3 == 0);
            @(negedge clk);
            if (tx_busy && !switched) begin
                u_if.tx_data = 8'h3C;
                switched     = 1'b1;
            end
            if (tx_done === 1'b1) begin
                dones++;
                if (dones == 1) begin
                    @(negedge clk);
                    baud_tick = 1'b0;
                    check_bit("b2b_second_accept", tx_busy, 1'b1);
                    u_if.tx_valid = 1'b0;
                end
            end
        end
        baud_tick = 1'b0;
        check_int("b2b_done_count", dones, 2);
        u_if.tx_valid = 1'b0;
        repeat (3) @(negedge clk);

        // Reset during data bit 3 of 0xA5, then 0xFF must go out cleanly.
        u_if.tx_valid = 1'b1;
        u_if.tx_data  = 8'hA5;
        @(negedge clk);
        u_if.tx_valid = 1'b0;
        repeat (5) begin
            baud_tick = 1'b1;
            @(negedge clk);
            baud_tick = 1'b0;
            @(negedge clk);
        end
        check_bit("pre_rst_bit3", tx_out, 1'b0);
        reset_n = 1'b0;
        @(negedge clk);
        check_bit("midrst_tx_out", tx_out, 1'b1);
        check_bit("midrst_done", tx_done, 1'b0);
        reset_n = 1'b1;
        @(negedge clk);
        check_bit("post_rst_ready", u_if.tx_ready, 1'b1);
        send_frame("ff_after_rst", 8'hFF, 2'b00, 1'b0, 16'b0111111111, 10);

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            reset_n       = ($urandom_range(0, 499) != 0);
            baud_tick     = ($urandom_range(0, 3) == 0);
            u_if.tx_valid = 1'($urandom);
            scramble_fields();
        end
        @(negedge clk);
        reset_n       = 1'b1;
        baud_tick     = 1'b0;
        u_if.tx_valid = 1'b0;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/uart_frame_tx.md
UART_FRAME_TX -- requirements
Module: uart_frame_tx

Interface
REQ-001 Parameter: DATA_WIDTH, 8, number of payload bits per frame; the bench uses 8.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset_n  input  1  reset, synchronous, active-low.
REQ-004 baud_tick  input  1  one-clk pulse per bit period; all line transitions align to it.
REQ-005 tx_data  input  DATA_WIDTH  payload, captured on handshake.
REQ-006 tx_valid  input  1  source offers tx_data.
REQ-007 tx_ready  output  1  block accepts a frame this cycle.
REQ-008 parity_type  input  2  01 odd, 10 even, 00/11 no parity bit; same encoding as the receive-side checker.
REQ-009 stop_bits  input  1  0 = one stop bit, 1 = two stop bits.
REQ-010 tx_out  output  1  serial line, idle high, registered.
REQ-011 tx_busy  output  1  frame in progress (any state other than IDLE).
REQ-012 tx_done  output  1  one-clk pulse when a frame's last stop bit completes.

Function
REQ-013 The FSM SHALL have states IDLE, ARM, START, DATA, PARITY and STOP.
REQ-014 tx_ready SHALL equal (state==IDLE); a frame is accepted on a clk edge with tx_valid & tx_ready.
REQ-015 On acceptance the block SHALL capture tx_data, parity_type and stop_bits into internal registers and enter ARM; later input changes SHALL NOT affect that frame.
REQ-016 In ARM tx_out SHALL stay 1 until the next baud_tick; a baud_tick in the acceptance cycle itself SHALL be ignored.
REQ-017 On that baud_tick the FSM SHALL enter START with tx_out=0 for one full tick interval.
REQ-018 Each subsequent baud_tick SHALL advance exactly one bit.
REQ-019 DATA SHALL send DATA_WIDTH bits LSB first using a bit counter 0..DATA_WIDTH-1.
REQ-020 After the last data bit the FSM SHALL go to PARITY if the captured parity_type is 01 or 10, else directly to STOP.
REQ-021 The parity bit SHALL be ^data for even parity and ~^data for odd parity, so the total number of ones in data plus parity is even or odd respectively.
REQ-022 STOP SHALL drive tx_out=1 for one or two tick intervals per the captured stop_bits.
REQ-023 The baud_tick that ends the final stop bit SHALL move the FSM to IDLE and pulse tx_done for exactly that one clk cycle.
REQ-024 tx_ready SHALL be high from the cycle after tx_done, allowing back-to-back frames with no added idle bit beyond the ARM wait.
REQ-025 Frame length from START entry to IDLE SHALL be 1+DATA_WIDTH+P+S baud_ticks (P=0/1, S=1/2).
REQ-026 tx_valid while tx_ready=0 SHALL be ignored and SHALL NOT be queued.
REQ-027 With no baud_tick the FSM SHALL hold its state and tx_out indefinitely.
REQ-028 tx_busy SHALL equal (state!=IDLE).
REQ-029 tx_out SHALL change only on a clk edge where baud_tick=1, or on reset.

Reset
REQ-030 When reset_n=0 at a clk edge the block SHALL set state=IDLE, tx_out=1, tx_done=0, tx_busy=0, and clear the bit counter and captured registers.
REQ-031 Reset mid-frame SHALL abandon the frame with no tx_done pulse; tx_ready SHALL be 1 on the first cycle after reset_n returns high.

Verification
REQ-032 tx_data=0xA5, parity=10, stop_bits=0 -> line after ARM tick: 0,1,0,1,0,0,1,0,1,0,1 (11 ticks) followed by one tx_done pulse.
REQ-033 tx_data=0x07 with parity=01 gives parity bit 0, and with parity=10 gives parity bit 1; tx_data=0xA5 with parity=01 gives parity bit 1.
REQ-034 tx_data=0x00, parity=11, stop_bits=1 -> 0 then eight 0s then 1,1 (11 ticks, no parity bit), then tx_done.
REQ-035 Back-to-back: tx_valid held high with 0x55 then 0x3C -> second frame accepted the cycle after tx_done; both frames on the line intact; busy-period tx_valid not double-counted.
REQ-036 Reset asserted during data bit 3 -> tx_out=1 next edge, no tx_done, tx_ready=1 after release; next frame 0xFF transmits correctly.
REQ-037 parity_type and tx_data toggled mid-frame -> the frame on the line matches the values captured at acceptance.
